// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: carries PC+2 and the fetched instruction from fetch to decode
// over a valid/ready handshake, with an optional two-entry skid buffer and flush-to-bubble.
module if_id_stage #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     SKID        = 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = {INSTR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [PC_WIDTH-1:0]    up_pc,
  input  logic [INSTR_WIDTH-1:0] up_instr,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  output logic [PC_WIDTH-1:0]    dn_pc,
  output logic [INSTR_WIDTH-1:0] dn_instr,
  output logic [1:0]             occupancy
);

  logic                   main_valid_q, main_valid_d;
  logic [PC_WIDTH-1:0]    main_pc_q,    main_pc_d;
  logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0]    skid_pc_q,    skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic                   up_ready_q,   up_ready_d;
  logic [1:0]             occ_q,        occ_d;
  logic                   up_ready_s;
  logic                   accept_s;
  logic                   issue_s;

  // With the skid buffer, up_ready comes straight from a flop; without it, it looks at dn_ready.
  always_comb begin
    up_ready_s = 1'b0;
    if (SKID != 0) begin
      up_ready_s = up_ready_q;
    end else begin
      up_ready_s = !main_valid_q || dn_ready;
    end
  end

  // Next-state for main/skid entries. The skid entry is always younger than main, so
  // when main drains it refills from skid before taking anything new from upstream.
  always_comb begin
    accept_s     = up_valid && up_ready_s;
    issue_s      = main_valid_q && dn_ready;
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = {PC_WIDTH{1'b0}};
      main_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !issue_s) begin
      // Stalled: main holds; a new word (only possible with SKID) parks in the skid slot.
      if (accept_s && (SKID != 0)) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = up_pc;
        skid_instr_d = up_instr;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      // up_ready is low whenever skid is occupied, so no accept can collide here.
      main_valid_d = 1'b1;
      main_pc_d    = skid_pc_q;
      main_instr_d = skid_instr_q;
      skid_valid_d = 1'b0;
    end else if (accept_s) begin
      main_valid_d = 1'b1;
      main_pc_d    = up_pc;
      main_instr_d = up_instr;
    end else begin
      // Draining to empty: present a bubble so decode never sees a stale instruction.
      main_valid_d = 1'b0;
      main_pc_d    = {PC_WIDTH{1'b0}};
      main_instr_d = NOP_INSTR;
    end

    up_ready_d = !skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers; reset drops every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= {PC_WIDTH{1'b0}};
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= {PC_WIDTH{1'b0}};
      skid_instr_q <= {INSTR_WIDTH{1'b0}};
      up_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      up_ready_q   <= up_ready_d;
      occ_q        <= occ_d;
    end
  end

  assign up_ready  = up_ready_s;
  assign dn_valid  = main_valid_q;
  assign dn_pc     = main_pc_q;
  assign dn_instr  = main_instr_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: SKID=1 and SKID=0 instances share stimulus and are each
// checked against a queue-based model of an in-order buffer with capacity 2 or 1.
module tb_if_id_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst, flush, uv, dr;
  logic [15:0] upc, uinstr;
  logic        ur1, dv1, ur0, dv0;
  logic [15:0] dpc1, din1, dpc0, din0;
  logic [1:0]  occ1, occ0;

  int    total = 0;
  int    bad   = 0;
  word_t q1[$];
  word_t q0[$];

  always #5 clk = ~clk;

  if_id_stage #(.PC_WIDTH(16), .INSTR_WIDTH(16), .SKID(1), .NOP_INSTR(16'h0000)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(uv), .up_ready(ur1), .up_pc(upc),
    .up_instr(uinstr), .dn_valid(dv1), .dn_ready(dr), .dn_pc(dpc1), .dn_instr(din1),
    .occupancy(occ1));

  if_id_stage #(.PC_WIDTH(16), .INSTR_WIDTH(16), .SKID(0), .NOP_INSTR(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(uv), .up_ready(ur0), .up_pc(upc),
    .up_instr(uinstr), .dn_valid(dv0), .dn_ready(dr), .dn_pc(dpc0), .dn_instr(din0),
    .occupancy(occ0));

  // Expected {up_ready, dn_valid, dn_pc, dn_instr, occupancy}: buffer of capacity 2
  function automatic logic [35:0] exp1();
    int n = q1.size();
    logic [15:0] p = (n > 0) ? q1[0].pc : 16'h0000;
    logic [15:0] i = (n > 0) ? q1[0].instr : 16'h0000;
    return {(n < 2), (n > 0), p, i, 2'(n)};
  endfunction

  // Capacity 1; up_ready also admits a word when the held one leaves this cycle
  function automatic logic [35:0] exp0();
    int n = q0.size();
    logic [15:0] p = (n > 0) ? q0[0].pc : 16'h0000;
    logic [15:0] i = (n > 0) ? q0[0].instr : 16'h0000;
    return {((n == 0) || (dr == 1'b1)), (n > 0), p, i, 2'(n)};
  endfunction

  // One clock: decide accepts/issues from the inputs and current contents, then update queues.
  task automatic tick();
    bit a1, i1, a0, i0;
    word_t w;
    w.pc = upc;
    w.instr = uinstr;
    a1 = uv && (q1.size() < 2);
    i1 = (q1.size() > 0) && dr;
    a0 = uv && ((q0.size() == 0) || dr);
    i0 = (q0.size() > 0) && dr;
    @(posedge clk);
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (i1) void'(q1.pop_front());
      if (a1) q1.push_back(w);
      if (i0) void'(q0.pop_front());
      if (a0) q0.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic flush_tick();
    uv = 1'b0; dr = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; uv = 1'b0; dr = 1'b0; upc = 16'h0; uinstr = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({ur1, dv1, dpc1, din1, occ1, ur0, dv0, dpc0, din0, occ0} !==
        {1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0}) begin
      bad++;
      $display("FAIL reset_held: got ur1=%b dv1=%b pc1=%h in1=%h occ1=%0d ur0=%b dv0=%b, want 1 0 0000 0000 0 1 0",
               ur1, dv1, dpc1, din1, occ1, ur0, dv0);
    end
    rst = 1'b0;
    @(negedge clk);
    tick();
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b1, 1'b0, 16'h0, 16'h0, 2'd0}) begin
      bad++;
      $display("FAIL reset_released: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 1 0 0000 0000 0",
               ur1, dv1, dpc1, din1, occ1);
    end
  endtask

  task automatic test_stream();
    logic [15:0] pcs [3];
    logic [15:0] ins [3];
    pcs[0] = 16'h3002; pcs[1] = 16'h3004; pcs[2] = 16'h3006;
    ins[0] = 16'h1021; ins[1] = 16'h5260; ins[2] = 16'h0E05;
    flush_tick();
    for (int k = 0; k < 3; k++) begin
      uv = 1'b1; dr = 1'b1; upc = pcs[k]; uinstr = ins[k];
      #1;
      total++;
      if (ur1 !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready_%0d: got up_ready=%b, want 1", k, ur1);
      end
      tick();
      total++;
      if ({dv1, dpc1, din1, occ1, dv0, dpc0, din0} !== {1'b1, pcs[k], ins[k], 2'd1, 1'b1, pcs[k], ins[k]}) begin
        bad++;
        $display("FAIL stream_word_%0d: got dv=%b pc=%h in=%h occ=%0d (skid0 dv=%b pc=%h in=%h), want 1 %h %h 1",
                 k, dv1, dpc1, din1, occ1, dv0, dpc0, din0, pcs[k], ins[k]);
      end
    end
    uv = 1'b0;
    tick();
    total++;
    if ({dv1, din1, occ1} !== {1'b0, 16'h0000, 2'd0}) begin
      bad++;
      $display("FAIL stream_drain: got dv=%b in=%h occ=%0d, want 0 0000 0", dv1, din1, occ1);
    end
  endtask

  task automatic test_skid_stall();
    flush_tick();
    uv = 1'b1; dr = 1'b0; upc = 16'h3002; uinstr = 16'h1021;
    tick();
    upc = 16'h3004; uinstr = 16'h5260;
    tick();
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b0, 1'b1, 16'h3002, 16'h1021, 2'd2}) begin
      bad++;
      $display("FAIL stall_full: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 0 1 3002 1021 2",
               ur1, dv1, dpc1, din1, occ1);
    end
    uv = 1'b0;
    tick();
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b0, 1'b1, 16'h3002, 16'h1021, 2'd2}) begin
      bad++;
      $display("FAIL stall_hold: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 0 1 3002 1021 2",
               ur1, dv1, dpc1, din1, occ1);
    end
    dr = 1'b1;
    tick();
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b1, 1'b1, 16'h3004, 16'h5260, 2'd1}) begin
      bad++;
      $display("FAIL stall_release: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 1 1 3004 5260 1",
               ur1, dv1, dpc1, din1, occ1);
    end
    tick();
    total++;
    if ({dv1, din1, occ1} !== {1'b0, 16'h0000, 2'd0}) begin
      bad++;
      $display("FAIL stall_no_dup: got dv=%b in=%h occ=%0d, want 0 0000 0", dv1, din1, occ1);
    end
  endtask

  task automatic test_flush();
    flush_tick();
    uv = 1'b1; dr = 1'b0; upc = 16'h3002; uinstr = 16'h1021;
    tick();
    upc = 16'h3004; uinstr = 16'h5260;
    tick();
    upc = 16'h3008; uinstr = 16'h2A10; flush = 1'b1;
    tick();
    flush = 1'b0; uv = 1'b0;
    total++;
    if ({ur1, dv1, dpc1, din1, occ1, dv0, din0, occ0} !==
        {1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0}) begin
      bad++;
      $display("FAIL flush_clear: got ur=%b dv=%b pc=%h in=%h occ=%0d (skid0 dv=%b occ=%0d), want 1 0 0000 0000 0",
               ur1, dv1, dpc1, din1, occ1, dv0, occ0);
    end
    dr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({dv1, dv0} !== 2'b00) begin
        bad++;
        $display("FAIL flush_no_leak_%0d: got dv1=%b pc1=%h dv0=%b, want no valid word", k, dv1, dpc1, dv0);
      end
    end
  endtask

  task automatic test_async_reset();
    flush_tick();
    uv = 1'b1; dr = 1'b0; upc = 16'h3002; uinstr = 16'h1021;
    tick();
    upc = 16'h3004; uinstr = 16'h5260;
    tick();
    uv = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b1, 1'b0, 16'h0, 16'h0, 2'd0}) begin
      bad++;
      $display("FAIL async_reset: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 1 0 0000 0000 0",
               ur1, dv1, dpc1, din1, occ1);
    end
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    uv = 1'b1; dr = 1'b1; upc = 16'h3010; uinstr = 16'h1234;
    tick();
    uv = 1'b0;
    total++;
    if ({ur1, dv1, dpc1, din1, occ1} !== {1'b1, 1'b1, 16'h3010, 16'h1234, 2'd1}) begin
      bad++;
      $display("FAIL async_reset_after: got ur=%b dv=%b pc=%h in=%h occ=%0d, want 1 1 3010 1234 1",
               ur1, dv1, dpc1, din1, occ1);
    end
    tick();
  endtask

  task automatic test_skid0_toggle();
    logic [15:0] pcs [4];
    logic [15:0] got [$];
    logic        ur_exp [3];
    int          pidx = 0;
    pcs[0] = 16'h4000; pcs[1] = 16'h4002; pcs[2] = 16'h4004; pcs[3] = 16'h4006;
    ur_exp[0] = 1'b1; ur_exp[1] = 1'b0; ur_exp[2] = 1'b1;
    flush_tick();
    uv = 1'b1; dr = 1'b0; upc = pcs[0]; uinstr = 16'h1000;
    tick();
    pidx = 1;
    for (int j = 0; j < 3; j++) begin
      dr = (j != 1);
      upc = pcs[pidx]; uinstr = 16'h1000 + 16'(pidx);
      #1;
      total++;
      if (ur0 !== ur_exp[j]) begin
        bad++;
        $display("FAIL skid0_ready_%0d: got up_ready=%b, want %b", j, ur0, ur_exp[j]);
      end
      if (j == 1) begin
        dr = 1'b1;
        #1;
        total++;
        if (ur0 !== 1'b1) begin
          bad++;
          $display("FAIL skid0_ready_comb: got up_ready=%b after dn_ready rose, want 1", ur0);
        end
        dr = 1'b0;
        #1;
      end
      if (dv0 && dr) got.push_back(dpc0);
      if (ur0) pidx++;
      tick();
    end
    uv = 1'b0;
    total++;
    if (got.size() != 2 || got[0] !== pcs[0] || got[1] !== pcs[1]) begin
      bad++;
      $display("FAIL skid0_throughput: got %0d issues (%h %h), want 2 issues 4000 4002",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, (got.size() > 1) ? got[1] : 16'hxxxx);
    end
    dr = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int prints = 0;
    logic [35:0] e1, e0, a1, a0;
    flush_tick();
    for (int c = 0; c < 10000; c++) begin
      uv     = ($urandom_range(0, 3) != 0);
      dr     = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 31) == 0);
      upc    = 16'($urandom);
      uinstr = 16'($urandom);
      #1;
      e1 = exp1();
      e0 = exp0();
      a1 = {ur1, dv1, (dv1 ? dpc1 : 16'h0000), din1, occ1};
      a0 = {ur0, dv0, (dv0 ? dpc0 : 16'h0000), din0, occ0};
      total++;
      if (a1 !== e1) begin
        bad++;
        if (prints < 20) $display("FAIL random_skid1 cycle %0d: got %h want %h", c, a1, e1);
        prints++;
      end
      total++;
      if (a0 !== e0) begin
        bad++;
        if (prints < 20) $display("FAIL random_skid0 cycle %0d: got %h want %h", c, a0, e0);
        prints++;
      end
      tick();
    end
    flush = 1'b0;
    uv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_stall();
    test_flush();
    test_async_reset();
    test_skid0_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised IF/ID pipeline stage register for the pipelined LC-3 core. It carries the PC+2 value and the fetched instruction from fetch to decode.
- Adds a valid/ready handshake, an optional two-entry skid buffer so that upstream ready is registered, and synchronous flush with NOP bubble insertion.
- It is the next generation of the plain load-enabled IF/ID flip-flop pair. It sits between the fetch stage (PC adder, I-cache/L2 path) and the decode/regfile stage.

Parameters:
- PC_WIDTH, 16, width of the PC field.
- INSTR_WIDTH, 16, width of the instruction field.
- SKID, 1, 1 = two-entry skid buffer with registered up_ready; 0 = single entry with combinational up_ready.
- NOP_INSTR, 16'h0000, instruction driven on dn_instr whenever dn_valid=0 (LC-3 BR with nzp=000).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- flush  input  1  discard all held entries (branch taken / mispredict)
- up_valid  input  1  fetch presents a valid PC/instruction
- up_ready  output  1  stage can accept this cycle
- up_pc  input  PC_WIDTH  PC+2 from fetch
- up_instr  input  INSTR_WIDTH  instruction from imem_rdata
- dn_valid  output  1  decode-side entry valid
- dn_ready  input  1  decode accepts (low = stall)
- dn_pc  output  PC_WIDTH  held PC+2
- dn_instr  output  INSTR_WIDTH  held instruction, or NOP_INSTR when invalid
- occupancy  output  2  entries held (0..2; 0..1 when SKID=0)

Behaviour:
- Reset (async, rst=1):
  - main_valid=0 and skid_valid=0.
  - dn_valid=0, dn_pc=0, dn_instr=NOP_INSTR, occupancy=0.
  - up_ready=1 while reset is asserted and after it is released.
  - Reset mid-transfer drops every entry, with no partial state.
- Transfers:
  - Accept occurs when up_valid && up_ready at a clk edge.
  - Issue occurs when dn_valid && dn_ready at a clk edge.
  - All outputs are driven from registers, except up_ready when SKID=0.
- SKID=1 states, named by occupancy:
  - EMPTY:
    - accept -> ONE; main <= up, latency 1 cycle from accept to dn_valid.
  - ONE:
    - accept and issue -> stay in ONE; main <= up.
    - accept without issue -> FULL; skid <= up.
    - issue without accept -> EMPTY.
    - neither -> hold.
  - FULL:
    - up_ready=0, so no accept is possible.
    - issue -> ONE; main <= skid.
    - no issue -> hold.
  - up_ready is registered: up_ready = !skid_valid.
  - FIFO order is preserved: the skid entry is always younger than the main entry.
- SKID=0:
  - up_ready = !main_valid || dn_ready, combinational.
  - Simultaneous accept and issue replaces main in the same edge, giving full throughput.
- Stall:
  - When dn_ready=0, the dn_* outputs are stable and unchanged for as long as dn_valid=1.
- Flush (synchronous, highest priority after rst):
  - At the edge: main_valid and skid_valid are cleared, dn_instr <= NOP_INSTR, dn_pc <= 0, occupancy <= 0.
  - An accept coincident with flush is discarded.
  - An issue coincident with flush still counts as consumed by decode; the stage does not re-present it.
  - The cycle after flush, up_ready=1.
- Invalid output:
  - Whenever dn_valid=0, dn_instr=NOP_INSTR so that decode sees a bubble even if it ignores dn_valid.
- Width rules:
  - Payload fields are copied verbatim; there is no arithmetic.
  - occupancy = main_valid + skid_valid.

Test Plan:
- Reset, then stream three words (pc 0x3002/0x3004/0x3006, instr 0x1021/0x5260/0x0E05) with dn_ready=1 -> each appears on dn_* exactly 1 cycle after accept, dn_valid continuous, up_ready constant 1, occupancy=1.
- SKID=1: accept 0x3002/0x1021, hold dn_ready=0, present 0x3004/0x5260 -> occupancy=2, up_ready=0 next cycle, dn_* stays 0x3002/0x1021. Raise dn_ready -> 0x3004/0x5260 issued next, no loss, no duplicate.
- Flush with occupancy=2 while up_valid=1 (0x3008/0x2A10) -> next cycle dn_valid=0, dn_instr=0x0000, dn_pc=0, occupancy=0, up_ready=1. The word 0x3008 never appears downstream.
- Assert rst asynchronously mid-cycle while FULL -> outputs go to reset values immediately, without waiting for clk. After release, the first accept behaves as from EMPTY.
- SKID=0 with dn_ready toggling 1,0,1 under continuous up_valid -> up_ready follows !main_valid||dn_ready combinationally, and exactly 2 words issue in 3 cycles in order.
- Random valid/ready/flush for 10k cycles against a queue scoreboard -> in-order delivery, no drops except entries flushed, and occupancy never above 2.
